xor_cipher_ctrl: RTL and testbench

XOR_CIPHER_CTRL -- requirements
Module: xor_cipher_ctrl

---
 rtl/xor_cipher_ctrl_pkg.sv | 16 +
 rtl/xor_cipher_ctrl_assembler.sv | 35 +++
 rtl/xor_cipher_ctrl.sv | 165 ++++++++++++++++
 tb/tb_xor_cipher_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xor_cipher_ctrl_pkg.sv
// Shared definitions for the XOR cipher controller: state encoding and sizing constants.
package xor_cipher_ctrl_pkg;

    localparam int unsigned DEFAULT_MSG_SIZE = 512;
    localparam int unsigned CNT_W            = $clog2(DEFAULT_MSG_SIZE) + 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_KEY,
        LOAD_MSG,
        ENCRYPT,
        STREAM,
        CLEAR
    } state_t;

endpackage

// File: rtl/xor_cipher_ctrl_assembler.sv
// Byte assembler: writes incoming bytes MSB-first into a wide register and counts loaded bits.
module cipher_byte_assembler
    import xor_cipher_ctrl_pkg::*;
#(
    parameter int unsigned MSG_SIZE = DEFAULT_MSG_SIZE
) (
    input  logic                iClk,
    input  logic                iRst,
    input  logic                iClear,
    input  logic                iLoad,
    input  logic [7:0]          iByte,
    output logic [MSG_SIZE-1:0] oData,
    output logic [CNT_W-1:0]    oCount,
    output logic                oLast_c
);

    localparam int unsigned IDX_W = $clog2(MSG_SIZE);

    logic [IDX_W-1:0] wrBase;

    // Bit count equals 8*k, so the k-th byte lands just below the bytes already written.
    assign wrBase  = IDX_W'(MSG_SIZE - 1) - IDX_W'(oCount);
    assign oLast_c = (oCount == CNT_W'(MSG_SIZE - 8));

    always_ff @(posedge iClk) begin
        if (iRst || iClear) begin
            oData  <= '0;
            oCount <= '0;
        end else if (iLoad && (oCount < CNT_W'(MSG_SIZE))) begin
            oData[wrBase -: 8] <= iByte;
            oCount             <= oCount + CNT_W'(8);
        end
    end

endmodule

// File: rtl/xor_cipher_ctrl.sv
// Controller for an XOR cipher core: loads key and message bytes, runs the core,
// then streams the ciphertext out a byte at a time.
module xor_cipher_ctrl
    import xor_cipher_ctrl_pkg::*;
#(
    parameter int unsigned MSG_SIZE = DEFAULT_MSG_SIZE
) (
    input  logic                iClk,
    input  logic                iRst,
    input  logic                iStart,
    input  logic                iReuse_key,
    input  logic [7:0]          iData,
    input  logic                iData_valid,
    output logic                oData_ready,
    output logic [MSG_SIZE-1:0] oKey,
    output logic [MSG_SIZE-1:0] oMessage,
    output logic [CNT_W-1:0]    oKey_assemble_counter,
    output logic [CNT_W-1:0]    oMessage_counter,
    output logic                oCan_encrypt,
    output logic                oCore_rst_n,
    input  logic                iEncrypt_done,
    input  logic [MSG_SIZE-1:0] iCiphertext,
    output logic [7:0]          oOut_data,
    output logic                oOut_valid,
    input  logic                iOut_ready,
    output logic                oBusy,
    output logic                oKey_held
);

    localparam int unsigned NB = MSG_SIZE / 8;

    state_t state, stateNext;

    logic                dataAccept;
    logic                keyClear, msgClear, keyLoad, msgLoad;
    logic                keyLast, msgLast;
    logic                capture, shiftOut;
    logic [MSG_SIZE-1:0] shiftReg;
    logic [CNT_W-1:0]    byteCnt;

    assign dataAccept = iData_valid && oData_ready;
    assign oOut_data  = shiftReg[MSG_SIZE-1 -: 8];

    cipher_byte_assembler #(.MSG_SIZE(MSG_SIZE)) keyAsm (
        .iClk    (iClk),
        .iRst    (iRst),
        .iClear  (keyClear),
        .iLoad   (keyLoad),
        .iByte   (iData),
        .oData   (oKey),
        .oCount  (oKey_assemble_counter),
        .oLast_c (keyLast)
    );

    cipher_byte_assembler #(.MSG_SIZE(MSG_SIZE)) msgAsm (
        .iClk    (iClk),
        .iRst    (iRst),
        .iClear  (msgClear),
        .iLoad   (msgLoad),
        .iByte   (iData),
        .oData   (oMessage),
        .oCount  (oMessage_counter),
        .oLast_c (msgLast)
    );

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        keyClear  = 1'b0;
        msgClear  = 1'b0;
        keyLoad   = 1'b0;
        msgLoad   = 1'b0;
        capture   = 1'b0;
        shiftOut  = 1'b0;
        case (state)
            IDLE: begin
                if (iStart) begin
                    msgClear = 1'b1;
                    if (iReuse_key && oKey_held) begin
                        stateNext = LOAD_MSG;
                    end else begin
                        keyClear  = 1'b1;
                        stateNext = LOAD_KEY;
                    end
                end
            end
            LOAD_KEY: begin
                if (dataAccept) begin
                    keyLoad = 1'b1;
                    if (keyLast) begin
                        stateNext = LOAD_MSG;
                    end
                end
            end
            LOAD_MSG: begin
                if (dataAccept) begin
                    msgLoad = 1'b1;
                    if (msgLast) begin
                        stateNext = ENCRYPT;
                    end
                end
            end
            ENCRYPT: begin
                if (iEncrypt_done) begin
                    capture   = 1'b1;
                    stateNext = STREAM;
                end
            end
            STREAM: begin
                if (iOut_ready) begin
                    shiftOut = 1'b1;
                    if (byteCnt == CNT_W'(NB - 1)) begin
                        stateNext = CLEAR;
                    end
                end
            end
            CLEAR: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Status outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            oData_ready  <= 1'b0;
            oCan_encrypt <= 1'b0;
            oOut_valid   <= 1'b0;
            oCore_rst_n  <= 1'b0;
            oBusy        <= 1'b0;
            oKey_held    <= 1'b0;
            shiftReg     <= '0;
            byteCnt      <= '0;
        end else begin
            oData_ready  <= (stateNext == LOAD_KEY) || (stateNext == LOAD_MSG);
            oCan_encrypt <= (stateNext == ENCRYPT);
            oOut_valid   <= (stateNext == STREAM);
            oCore_rst_n  <= (stateNext != CLEAR);
            oBusy        <= (stateNext != IDLE);
            if (keyClear) begin
                oKey_held <= 1'b0;
            end else if (keyLoad && keyLast) begin
                oKey_held <= 1'b1;
            end
            if (capture) begin
                shiftReg <= iCiphertext;
                byteCnt  <= '0;
            end else if (shiftOut) begin
                shiftReg <= {shiftReg[MSG_SIZE-9:0], 8'h00};
                byteCnt  <= byteCnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_xor_cipher_ctrl.sv
// Scoreboard bench for xor_cipher_ctrl with a behavioural XOR core attached.
module tb_xor_cipher_ctrl;

    localparam int unsigned MS = 512;
    localparam int unsigned NB = MS / 8;

    logic          iClk;
    logic          iRst;
    logic          iStart;
    logic          iReuse_key;
    logic [7:0]    iData;
    logic          iData_valid;
    logic          oData_ready;
    logic [MS-1:0] oKey;
    logic [MS-1:0] oMessage;
    logic [9:0]    oKey_assemble_counter;
    logic [9:0]    oMessage_counter;
    logic          oCan_encrypt;
    logic          oCore_rst_n;
    logic          iEncrypt_done;
    logic [MS-1:0] iCiphertext;
    logic [7:0]    oOut_data;
    logic          oOut_valid;
    logic          iOut_ready;
    logic          oBusy;
    logic          oKey_held;

    int          tests = 0;
    int          fails = 0;
    logic [7:0]  expQ[$];
    logic [7:0]  keyModel[NB];
    bit          bpMode = 1'b0;

    xor_cipher_ctrl #(.MSG_SIZE(MS)) dut (
        .iClk                  (iClk),
        .iRst                  (iRst),
        .iStart                (iStart),
        .iReuse_key            (iReuse_key),
        .iData                 (iData),
        .iData_valid           (iData_valid),
        .oData_ready           (oData_ready),
        .oKey                  (oKey),
        .oMessage              (oMessage),
        .oKey_assemble_counter (oKey_assemble_counter),
        .oMessage_counter      (oMessage_counter),
        .oCan_encrypt          (oCan_encrypt),
        .oCore_rst_n           (oCore_rst_n),
        .iEncrypt_done         (iEncrypt_done),
        .iCiphertext           (iCiphertext),
        .oOut_data             (oOut_data),
        .oOut_valid            (oOut_valid),
        .iOut_ready            (iOut_ready),
        .oBusy                 (oBusy),
        .oKey_held             (oKey_held)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    // Behavioural core: completes one edge after enable with both registers full, latches done.
    always @(posedge iClk) begin
        if (!oCore_rst_n) begin
            iEncrypt_done <= 1'b0;
            iCiphertext   <= '0;
        end else if (oCan_encrypt && !iEncrypt_done &&
                     oKey_assemble_counter == 10'd512 && oMessage_counter == 10'd512) begin
            iEncrypt_done <= 1'b1;
            iCiphertext   <= oKey ^ oMessage;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chkW(input string name, input logic [MS-1:0] act, input logic [MS-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Sink ready: always 1, or toggling every cycle under backpressure.
    initial begin
        iOut_ready = 1'b1;
        forever begin
            @(posedge iClk);
            #1;
            iOut_ready = bpMode ? ~iOut_ready : 1'b1;
        end
    end

    // Monitor: pops the scoreboard on each output handshake and checks stall stability.
    initial begin
        logic [7:0] holdData;
        logic [7:0] expByte;
        bit         holdPending;
        holdPending = 1'b0;
        holdData    = 8'h00;
        forever begin
            @(negedge iClk);
            if (iRst == 1'b0 && oOut_valid == 1'b1) begin
                if (holdPending) chk("stall_hold", 32'(oOut_data), 32'(holdData));
                if (iOut_ready) begin
                    holdPending = 1'b0;
                    if (expQ.size() == 0) begin
                        chk("unexpected_out_queue", 32'(expQ.size()), 32'd1);
                    end else begin
                        expByte = expQ.pop_front();
                        chk("out_byte", 32'(oOut_data), 32'(expByte));
                    end
                end else begin
                    holdPending = 1'b1;
                    holdData    = oOut_data;
                end
            end else begin
                holdPending = 1'b0;
            end
        end
    end

    function automatic logic [7:0] patByte(input int mode, input int k);
        case (mode)
            0:       return 8'hA5;
            1:       return 8'(k);
            2:       return 8'hFF;
            3:       return 8'(k * 7 + 3);
            default: return 8'(8'h40 + k);
        endcase
    endfunction

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic pulseStart(input bit reuse);
        iReuse_key = reuse;
        iStart     = 1'b1;
        tick();
        iStart     = 1'b0;
        iReuse_key = 1'b0;
    endtask

    task automatic sendByte(input logic [7:0] b, input int gapMax);
        int n;
        if (gapMax > 0) begin
            n = $urandom_range(0, gapMax);
            repeat (n) begin
                iData = 8'($urandom);
                tick();
            end
        end
        iData       = b;
        iData_valid = 1'b1;
        n = 0;
        while (!oData_ready && n < 100) begin
            tick();
            n++;
        end
        if (!oData_ready) chk("ready_timeout", 32'(oData_ready), 32'd1);
        tick();
        iData_valid = 1'b0;
    endtask

    task automatic checkResetState();
        chkW("rst_key", oKey, '0);
        chkW("rst_msg", oMessage, '0);
        chk("rst_key_cnt", 32'(oKey_assemble_counter), 0);
        chk("rst_msg_cnt", 32'(oMessage_counter), 0);
        chk("rst_key_held", 32'(oKey_held), 0);
        chk("rst_can_enc", 32'(oCan_encrypt), 0);
        chk("rst_out_valid", 32'(oOut_valid), 0);
        chk("rst_data_ready", 32'(oData_ready), 0);
        chk("rst_core_rst_n", 32'(oCore_rst_n), 0);
        chk("rst_busy", 32'(oBusy), 0);
        chk("rst_out_data", 32'(oOut_data), 0);
    endtask

    task automatic runTxn(input bit reuse, input bit expectKeyLoad, input int keyMode,
                          input int msgMode, input int gapMax, input bit startInStream);
        logic [MS-1:0] keyVec;
        logic [MS-1:0] msgVec;
        logic [7:0]    m;
        int            n;
        keyVec = '0;
        msgVec = '0;
        pulseStart(reuse);
        chk("start_ready", 32'(oData_ready), 1);
        chk("start_msg_cnt", 32'(oMessage_counter), 0);
        if (expectKeyLoad) begin
            chk("start_key_cnt", 32'(oKey_assemble_counter), 0);
            for (int k = 0; k < NB; k++) begin
                keyModel[k] = patByte(keyMode, k);
                sendByte(keyModel[k], gapMax);
                if (gapMax > 0) chk("key_cnt", 32'(oKey_assemble_counter), 32'(8 * (k + 1)));
            end
            chk("key_held_set", 32'(oKey_held), 1);
        end else begin
            chk("reuse_key_cnt", 32'(oKey_assemble_counter), 32'(MS));
        end
        for (int k = 0; k < NB; k++) begin
            m      = patByte(msgMode, k);
            msgVec = {msgVec[MS-9:0], m};
            keyVec = {keyVec[MS-9:0], keyModel[k]};
            expQ.push_back(keyModel[k] ^ m);
            sendByte(m, gapMax);
            if (gapMax > 0) begin
                chk("msg_cnt", 32'(oMessage_counter), 32'(8 * (k + 1)));
                if (k < NB - 1) chk("early_encrypt", 32'(oCan_encrypt), 0);
            end
        end
        chk("enc_entry", 32'(oCan_encrypt), 1);
        chk("enc_ready_low", 32'(oData_ready), 0);
        chk("enc_msg_cnt", 32'(oMessage_counter), 32'(MS));
        chkW("key_vec", oKey, keyVec);
        chkW("msg_vec", oMessage, msgVec);
        chk("lat1_valid", 32'(oOut_valid), 0);
        tick();
        chk("lat2_valid", 32'(oOut_valid), 0);
        chk("lat2_can_enc", 32'(oCan_encrypt), 1);
        tick();
        chk("lat3_valid", 32'(oOut_valid), 1);
        chk("lat3_can_enc", 32'(oCan_encrypt), 0);
        if (startInStream) begin
            iStart = 1'b1;
            tick();
            iStart = 1'b0;
            chk("stream_start_ready", 32'(oData_ready), 0);
            chk("stream_start_valid", 32'(oOut_valid), 1);
        end
        n = 0;
        while (oCore_rst_n && n < 2000) begin
            tick();
            n++;
        end
        chk("clear_seen", 32'(oCore_rst_n), 0);
        chk("clear_busy", 32'(oBusy), 1);
        chk("queue_drained", 32'(expQ.size()), 0);
        tick();
        chk("clear_one_cycle", 32'(oCore_rst_n), 1);
        chk("idle_busy", 32'(oBusy), 0);
        chk("idle_valid", 32'(oOut_valid), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        iRst        = 1'b1;
        iStart      = 1'b0;
        iReuse_key  = 1'b0;
        iData       = 8'h00;
        iData_valid = 1'b0;
        repeat (3) tick();
        checkResetState();
        iRst = 1'b0;
        tick();
        chk("post_rst_core_rst_n", 32'(oCore_rst_n), 1);

        // Full flow: key all A5, message 0..63.
        runTxn(1'b0, 1'b1, 0, 1, 0, 1'b0);

        // Key reuse with message all FF -> every output byte 5A.
        runTxn(1'b1, 1'b0, 0, 2, 0, 1'b0);

        // Backpressure plus a stray start during STREAM.
        bpMode = 1'b1;
        runTxn(1'b1, 1'b0, 0, 3, 0, 1'b1);
        bpMode = 1'b0;
        tick();

        // Data valid while idle must be ignored.
        iData       = 8'h77;
        iData_valid = 1'b1;
        repeat (3) tick();
        chk("idle_ignore_key_cnt", 32'(oKey_assemble_counter), 32'(MS));
        chk("idle_ignore_msg_cnt", 32'(oMessage_counter), 32'(MS));
        chk("idle_ignore_busy", 32'(oBusy), 0);
        iData_valid = 1'b0;

        // New key with random valid gaps.
        runTxn(1'b0, 1'b1, 4, 1, 3, 1'b0);

        // Reset after 30 message bytes.
        pulseStart(1'b0);
        for (int k = 0; k < NB; k++) sendByte(patByte(0, k), 0);
        for (int k = 0; k < 30; k++) sendByte(patByte(1, k), 0);
        chk("pre_rst_msg_cnt", 32'(oMessage_counter), 240);
        iRst = 1'b1;
        tick();
        checkResetState();
        iRst = 1'b0;
        tick();
        chk("mid_rst_core_rst_n", 32'(oCore_rst_n), 1);
        chk("mid_rst_key_held", 32'(oKey_held), 0);

        // Reuse requested but no key held -> key load required.
        runTxn(1'b1, 1'b1, 3, 2, 0, 1'b0);

        repeat (2) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
